// File: rtl/dram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dram_sched_pkg
// Purpose : Shared types and constants for the two-port DRAM request
//           scheduler: FSM state encoding, DRAM command pin patterns,
//           data-mask idle value and an address-range helper.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package dram_sched_pkg;

    // Scheduler states. Encoding is fixed so waveforms are stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_DONE    = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    // Command pin patterns, ordered {cs, ras, cas, we}, all active-low.
    localparam logic [3:0] CMD_NOP = 4'b1111;
    localparam logic [3:0] CMD_RD  = 4'b0001;
    localparam logic [3:0] CMD_WR  = 4'b0000;

    // Data mask value when no byte is being written.
    localparam logic [3:0] DM_NONE = 4'hF;

    // Width of the DRAM address and bank pins.
    localparam int DRAM_AW = 14;
    localparam int DRAM_BW = 3;

    // Mask selecting the byte-address bits above the memory's word range.
    // Any set bit under this mask means the access is out of range.
    function automatic logic [31:0] hi_addr_mask(input int mem_aw);
        return ~((32'h1 << (mem_aw + 2)) - 32'h1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Purpose : Two-input round-robin arbiter (combinational). A lone requester
//           always wins; on a tie, the port that did not win last time wins.
// Ports   : req[1:0]    - request vector, bit N = port N
//           last_grant  - index of the port granted most recently
//           grant[1:0]  - one-hot grant, all zero when nothing requests
// Revision: 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: hand the bus to the port that did not have it last.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dram_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : dram_req_scheduler
// Purpose : Two-port word request scheduler and command sequencer for the
//           LPDDR4 model memory. Arbitrates round-robin between port 0
//           (instruction fetch) and port 1 (load/store), issues one
//           read/write command per transaction on the active-low command
//           pins, drives the shared dq bus for writes, captures read data
//           and returns per-port ack/err/rdata. Every output is registered.
// Ports   : clk, rst            - clock, async active-high reset
//           pN_req/we/addr/     - port N request, held until pN_ack
//           wdata/wstrb
//           pN_ack/err/rdata    - port N one-cycle completion, range error,
//                                 read data (held until next read ack)
//           dram_cs/ras/cas/we  - active-low command pins
//           dram_addr, dram_ba  - word address, bank (always 0)
//           dram_dq             - shared tristate data bus
//           dram_dm, dram_dqs   - write data mask / strobe
// Revision: 1.0  initial release
// ============================================================================
module dram_req_scheduler
    import dram_sched_pkg::*;
#(
    parameter int MEM_AW   = 10,  // memory word-address width, at most 14
    parameter int TURN_CYC = 1    // idle cycles after each transaction, 0..15
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic [31:0]          p0_addr,
    input  logic [31:0]          p0_wdata,
    input  logic [3:0]           p0_wstrb,
    output logic                 p0_ack,
    output logic                 p0_err,
    output logic [31:0]          p0_rdata,

    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic [31:0]          p1_addr,
    input  logic [31:0]          p1_wdata,
    input  logic [3:0]           p1_wstrb,
    output logic                 p1_ack,
    output logic                 p1_err,
    output logic [31:0]          p1_rdata,

    output logic                 dram_cs,
    output logic                 dram_ras,
    output logic                 dram_cas,
    output logic                 dram_we,
    output logic [DRAM_AW-1:0]   dram_addr,
    output logic [DRAM_BW-1:0]   dram_ba,
    inout  wire  [31:0]          dram_dq,
    output logic [3:0]           dram_dm,
    output logic                 dram_dqs
);

    localparam logic [31:0] ADDR_HI_MASK = hi_addr_mask(MEM_AW);
    // Last TURN count value; unused when TURN_CYC is 0 since TURN is skipped.
    localparam logic [3:0]  TURN_LAST    = 4'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_grant;       // one-hot owner of the current transaction
    logic               r_last_grant;  // index of the most recently granted port
    logic               r_we;          // current transaction is a write
    logic [3:0]         r_turn_cnt;

    // Registered outputs
    logic [3:0]         r_cmd;
    logic [DRAM_AW-1:0] r_dram_addr;
    logic [3:0]         r_dm;
    logic               r_dqs;
    logic               r_dq_oe;
    logic [31:0]        r_dq_out;
    logic [1:0]         r_ack;
    logic [1:0]         r_err;
    logic [31:0]        r_rdata0;
    logic [31:0]        r_rdata1;

    // ------------------------------------------------------------------
    // Arbitration and selected-port request fields (used in IDLE only)
    // ------------------------------------------------------------------
    logic [1:0]         w_grant;
    logic               w_sel_we;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_wstrb;
    logic               w_addr_err;
    logic [DRAM_AW-1:0] w_word_addr;

    rr_arb2 u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_comb begin
        w_sel_we    = w_grant[1] ? p1_we    : p0_we;
        w_sel_addr  = w_grant[1] ? p1_addr  : p0_addr;
        w_sel_wdata = w_grant[1] ? p1_wdata : p0_wdata;
        w_sel_wstrb = w_grant[1] ? p1_wstrb : p0_wstrb;
        w_addr_err  = |(w_sel_addr & ADDR_HI_MASK);
        // Zero-extend the word address onto the DRAM address pins.
        w_word_addr = '0;
        w_word_addr[MEM_AW-1:0] = w_sel_addr[MEM_AW+1:2];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    // Out-of-range accesses skip the DRAM entirely.
                    w_state_next = w_addr_err ? ST_DONE : ST_CMD;
                end
            end
            ST_CMD:     w_state_next = r_we ? ST_DONE : ST_RD_WAIT;
            ST_RD_WAIT: w_state_next = ST_DONE;
            ST_DONE:    w_state_next = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;
            ST_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs.
    // Pin values for a cycle are computed in the cycle before, so the
    // command pins, dq drive and ack all come straight from flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;      // port 0 wins the first tie
            r_we         <= 1'b0;
            r_turn_cnt   <= 4'd0;
            r_cmd        <= CMD_NOP;
            r_dram_addr  <= '0;
            r_dm         <= DM_NONE;
            r_dqs        <= 1'b0;
            r_dq_oe      <= 1'b0;
            r_dq_out     <= 32'h0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
            r_rdata0     <= 32'h0;
            r_rdata1     <= 32'h0;
        end else begin
            // Single-cycle pulses and idle pin levels by default.
            r_ack   <= 2'b00;
            r_err   <= 2'b00;
            r_cmd   <= CMD_NOP;
            r_dm    <= DM_NONE;
            r_dqs   <= 1'b0;
            r_dq_oe <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant[1];
                        r_we         <= w_sel_we;
                        if (w_addr_err) begin
                            // Next cycle is DONE: flag the error with the ack.
                            r_ack <= w_grant;
                            r_err <= w_grant;
                        end else begin
                            r_cmd       <= w_sel_we ? CMD_WR : CMD_RD;
                            r_dram_addr <= w_word_addr;
                            if (w_sel_we) begin
                                r_dq_oe  <= 1'b1;
                                r_dq_out <= w_sel_wdata;
                                r_dm     <= ~w_sel_wstrb;
                                r_dqs    <= 1'b1;
                            end
                        end
                    end
                end
                ST_CMD: begin
                    // Writes complete right after the command cycle.
                    if (r_we) begin
                        r_ack <= r_grant;
                    end
                end
                ST_RD_WAIT: begin
                    // The memory drives dq throughout this cycle.
                    if (r_grant[1]) begin
                        r_rdata1 <= dram_dq;
                    end else begin
                        r_rdata0 <= dram_dq;
                    end
                    r_ack <= r_grant;
                end
                ST_DONE: begin
                    r_turn_cnt <= 4'd0;
                end
                ST_TURN: begin
                    r_turn_cnt <= r_turn_cnt + 4'd1;
                end
                default: begin
                    r_turn_cnt <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign {dram_cs, dram_ras, dram_cas, dram_we} = r_cmd;
    assign dram_addr = r_dram_addr;
    assign dram_ba   = '0;
    assign dram_dm   = r_dm;
    assign dram_dqs  = r_dqs;
    assign dram_dq   = r_dq_oe ? r_dq_out : 32'hzzzz_zzzz;

    assign p0_ack    = r_ack[0];
    assign p1_ack    = r_ack[1];
    assign p0_err    = r_err[0];
    assign p1_err    = r_err[1];
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dram_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_dram_req_scheduler
// Purpose : Self-checking bench for dram_req_scheduler. Instance A uses
//           TURN_CYC=1 with a read/write memory model; instance B uses
//           TURN_CYC=0 with a read-only preloaded image.
// Revision: 1.0  initial release
// ============================================================================
module tb_dram_req_scheduler;
    import dram_sched_pkg::*;

    localparam int MEM_AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Preloaded memory image word i
    function automatic logic [31:0] img(input int i);
        logic [15:0] lo;
        lo = 16'(i);
        return {16'hC0DE, lo};
    endfunction

    // ------------------------------------------------------------------
    // Instance A: TURN_CYC = 1
    // ------------------------------------------------------------------
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  ack, err;
    logic [31:0] rdata [2];
    logic        cs, ras, cas, dwe, dqs;
    logic [13:0] daddr;
    logic [2:0]  ba;
    logic [3:0]  dm;
    tri1  [31:0] dq;

    dram_req_scheduler #(.MEM_AW(MEM_AW), .TURN_CYC(1)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_wstrb(wstrb[0]), .p0_ack(ack[0]), .p0_err(err[0]), .p0_rdata(rdata[0]),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_wstrb(wstrb[1]), .p1_ack(ack[1]), .p1_err(err[1]), .p1_rdata(rdata[1]),
        .dram_cs(cs), .dram_ras(ras), .dram_cas(cas), .dram_we(dwe),
        .dram_addr(daddr), .dram_ba(ba), .dram_dq(dq), .dram_dm(dm), .dram_dqs(dqs)
    );

    // Memory model A: drives dq in the cycle after a read command.
    logic [31:0] mem [1024];
    logic        mem_oe = 1'b0;
    logic [31:0] mem_q  = 32'h0;
    assign dq = mem_oe ? mem_q : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        mem_oe <= 1'b0;
        if ({cs, ras, cas, dwe} == CMD_RD) begin
            mem_oe <= 1'b1;
            mem_q  <= mem[daddr[9:0]];
        end
        if ({cs, ras, cas, dwe} == CMD_WR) begin
            for (int b = 0; b < 4; b++)
                if (!dm[b]) mem[daddr[9:0]][8*b +: 8] <= dq[8*b +: 8];
        end
    end

    // dq must float (reads back as the pull-up) whenever neither end owns it.
    always @(negedge clk) begin
        if (!mem_oe && {cs, ras, cas, dwe} != CMD_WR)
            check("dq released", dq, 32'hFFFF_FFFF);
    end

    // ------------------------------------------------------------------
    // Instance B: TURN_CYC = 0, port 0 reads only
    // ------------------------------------------------------------------
    logic        b_req = 1'b0;
    logic [31:0] b_addr = 32'h0;
    logic        b_ack, b_err, b_ack1, b_err1;
    logic [31:0] b_rdata, b_rdata1;
    logic        b_cs, b_ras, b_cas, b_dwe, b_dqs;
    logic [13:0] b_daddr;
    logic [2:0]  b_ba;
    logic [3:0]  b_dm;
    tri1  [31:0] b_dq;
    logic        b_oe = 1'b0;
    logic [31:0] b_q  = 32'h0;

    dram_req_scheduler #(.MEM_AW(MEM_AW), .TURN_CYC(0)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(b_req), .p0_we(1'b0), .p0_addr(b_addr), .p0_wdata(32'h0),
        .p0_wstrb(4'h0), .p0_ack(b_ack), .p0_err(b_err), .p0_rdata(b_rdata),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(32'h0), .p1_wdata(32'h0),
        .p1_wstrb(4'h0), .p1_ack(b_ack1), .p1_err(b_err1), .p1_rdata(b_rdata1),
        .dram_cs(b_cs), .dram_ras(b_ras), .dram_cas(b_cas), .dram_we(b_dwe),
        .dram_addr(b_daddr), .dram_ba(b_ba), .dram_dq(b_dq), .dram_dm(b_dm), .dram_dqs(b_dqs)
    );

    assign b_dq = b_oe ? b_q : 32'hzzzz_zzzz;
    always @(posedge clk) begin
        b_oe <= ({b_cs, b_ras, b_cas, b_dwe} == CMD_RD);
        b_q  <= img(int'(b_daddr[9:0]));
    end

    // ------------------------------------------------------------------
    // Transaction table for instance A
    // ------------------------------------------------------------------
    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_cmd;
        logic [13:0] exp_daddr;
        logic [3:0]  exp_dm;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mkv(input int p, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] ws, input int lat,
                                 input logic e, input logic [31:0] rd, input logic [3:0] c,
                                 input logic [13:0] da, input logic [3:0] m);
        vec_t v;
        v.port = p; v.we = w; v.addr = a; v.wdata = wd; v.wstrb = ws;
        v.exp_lat = lat; v.exp_err = e; v.exp_rdata = rd; v.exp_cmd = c;
        v.exp_daddr = da; v.exp_dm = m;
        return v;
    endfunction

    // Starts in an IDLE cycle; ends in the TURN cycle after the ack.
    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          cmd_k;
        logic [3:0]  cmd_v;
        logic [13:0] a_v;
        logic [3:0]  dm_v;
        logic [31:0] dq_v;
        logic        dqs_v, e_v, other;
        logic [31:0] rd_v;
        lat = 0; cmd_k = 0; cmd_v = CMD_NOP; a_v = '0; dm_v = '0; dq_v = '0;
        dqs_v = 1'b0; e_v = 1'b0; other = 1'b0; rd_v = '0;
        @(negedge clk);
        req[v.port]   = 1'b1;
        we[v.port]    = v.we;
        addr[v.port]  = v.addr;
        wdata[v.port] = v.wdata;
        wstrb[v.port] = v.wstrb;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if ({cs, ras, cas, dwe} != CMD_NOP) begin
                cmd_k = k; cmd_v = {cs, ras, cas, dwe};
                a_v = daddr; dm_v = dm; dq_v = dq; dqs_v = dqs;
            end
            if (ack[1 - v.port]) other = 1'b1;
            if (ack[v.port]) begin
                lat = k; e_v = err[v.port]; rd_v = rdata[v.port];
                break;
            end
        end
        req[v.port] = 1'b0;
        check($sformatf("v%0d ack latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d err", idx), 32'(e_v), 32'(v.exp_err));
        check($sformatf("v%0d rdata", idx), rd_v, v.exp_rdata);
        check($sformatf("v%0d other ack", idx), 32'(other), 32'h0);
        check($sformatf("v%0d command", idx), 32'(cmd_v), 32'(v.exp_cmd));
        if (v.exp_cmd != CMD_NOP) begin
            check($sformatf("v%0d cmd cycle", idx), 32'(cmd_k), 32'd1);
            check($sformatf("v%0d dram_addr", idx), 32'(a_v), 32'(v.exp_daddr));
            check($sformatf("v%0d dm", idx), 32'(dm_v), 32'(v.exp_dm));
            check($sformatf("v%0d dqs", idx), 32'(dqs_v), 32'(v.exp_cmd == CMD_WR));
            if (v.exp_cmd == CMD_WR)
                check($sformatf("v%0d dq write data", idx), dq_v, v.wdata);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int          na;
    int          ak [4];
    int          ap [4];
    logic [31:0] ad [4];
    int          exp_k [4];
    int          exp_p [4];
    int          k0, k1;
    logic [31:0] d0, d1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0;
        end
        for (int i = 0; i < 1024; i++) mem[i] = img(i);

        vecs[0] = mkv(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, 32'h0,         CMD_WR,  14'h004, 4'h0);
        vecs[1] = mkv(1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 3, 1'b0, 32'hDEAD_BEEF, CMD_RD,  14'h004, 4'hF);
        vecs[2] = mkv(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'h3, 2, 1'b0, 32'h0,         CMD_WR,  14'h008, 4'hC);
        vecs[3] = mkv(0, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 3, 1'b0, 32'hC0DE_3344, CMD_RD,  14'h008, 4'hF);
        vecs[4] = mkv(0, 1'b0, 32'h0000_1000, 32'h0,         4'h0, 1, 1'b1, 32'hC0DE_3344, CMD_NOP, 14'h000, 4'hF);
        vecs[5] = mkv(0, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 3, 1'b0, 32'hC0DE_03FF, CMD_RD,  14'h3FF, 4'hF);
        vecs[6] = mkv(1, 1'b1, 32'h0000_0FFF, 32'hAB00_0000, 4'h8, 2, 1'b0, 32'hDEAD_BEEF, CMD_WR,  14'h3FF, 4'h7);
        vecs[7] = mkv(1, 1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 3, 1'b0, 32'hABDE_03FF, CMD_RD,  14'h3FF, 4'hF);
        vecs[8] = mkv(1, 1'b1, 32'h8000_0000, 32'h5555_5555, 4'hF, 1, 1'b1, 32'hABDE_03FF, CMD_NOP, 14'h000, 4'hF);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ack",   32'(ack), 32'h0);
        check("rst err",   32'(err), 32'h0);
        check("rst rdata0", rdata[0], 32'h0);
        check("rst rdata1", rdata[1], 32'h0);
        check("rst cmd pins", 32'({cs, ras, cas, dwe}), 32'hF);
        check("rst dram_addr", 32'(daddr), 32'h0);
        check("rst dram_ba", 32'(ba), 32'h0);
        check("rst dm", 32'(dm), 32'hF);
        check("rst dqs", 32'(dqs), 32'h0);
        check("rst B ack", 32'(b_ack), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Both ports read from reset, held continuously: grants alternate.
        na = 0;
        exp_k[0] = 3;  exp_k[1] = 8;  exp_k[2] = 13; exp_k[3] = 18;
        exp_p[0] = 0;  exp_p[1] = 1;  exp_p[2] = 0;  exp_p[3] = 1;
        for (int i = 0; i < 4; i++) begin ak[i] = -1; ap[i] = -1; ad[i] = 32'h0; end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req = 2'b11; we = 2'b00; addr[0] = 32'h40; addr[1] = 32'h44;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (ack[p] && na < 4) begin
                    ak[na] = k; ap[na] = p; ad[na] = rdata[p]; na++;
                end
            end
        end
        req = 2'b00;
        check("tie ack count", 32'(na), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie ack%0d cycle", i), 32'(ak[i]), 32'(exp_k[i]));
            check($sformatf("tie ack%0d port", i), 32'(ap[i]), 32'(exp_p[i]));
            check($sformatf("tie ack%0d rdata", i), ad[i], img(16 + exp_p[i]));
        end

        // Reset during RD_WAIT drops the transaction.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h48;
        @(negedge clk);
        check("abort cmd issued", 32'({cs, ras, cas, dwe}), 32'(CMD_RD));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ack", 32'(ack), 32'h0);
        check("abort rdata0", rdata[0], 32'h0);
        check("abort cmd pins", 32'({cs, ras, cas, dwe}), 32'hF);
        check("abort dram_addr", 32'(daddr), 32'h0);
        check("abort dm", 32'(dm), 32'hF);
        @(negedge clk);
        req[0] = 1'b0; rst = 1'b0;
        na = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (|ack) na++;
        end
        check("abort no ack", 32'(na), 32'h0);

        // After reset a tie goes to port 0 first.
        k0 = -1; k1 = -1; d0 = 32'h0; d1 = 32'h0;
        req = 2'b11; we = 2'b00; addr[0] = 32'h48; addr[1] = 32'h4C;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ack[0] && k0 < 0) begin k0 = k; d0 = rdata[0]; req[0] = 1'b0; end
            if (ack[1] && k1 < 0) begin k1 = k; d1 = rdata[1]; req[1] = 1'b0; end
        end
        req = 2'b00;
        check("post-rst p0 ack cycle", 32'(k0), 32'd3);
        check("post-rst p0 rdata", d0, img(18));
        check("post-rst p1 ack cycle", 32'(k1), 32'd8);
        check("post-rst p1 rdata", d1, img(19));

        // TURN_CYC=0: back-to-back port 0 reads of words 0 and 1.
        k0 = -1; k1 = -1; d0 = 32'h0; d1 = 32'h0;
        @(negedge clk);
        b_req = 1'b1; b_addr = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b_ack) begin
                if (k0 < 0) begin
                    k0 = k; d0 = b_rdata; b_addr = 32'h4;
                end else if (k1 < 0) begin
                    k1 = k; d1 = b_rdata; b_req = 1'b0;
                end
            end
        end
        b_req = 1'b0;
        check("b2b first ack cycle", 32'(k0), 32'd3);
        check("b2b ack spacing", 32'(k1 - k0), 32'd4);
        check("b2b word0 rdata", d0, img(0));
        check("b2b word1 rdata", d1, img(1));

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_req_scheduler.md
# dram_req_scheduler

Two-port request scheduler and command sequencer for the LPDDR4 model memory in the SoC-32bit DRAM testbench. It accepts word read/write requests from two masters (port 0: instruction fetch, port 1: load/store), arbitrates round-robin, and drives the active-low cs/ras/cas/we command pins and the shared tristate dq bus. It captures read data one cycle after the command and returns per-port ack/err/rdata.

## Interface
- `MEM_AW`, 10, word-address width of the memory; byte address bits [MEM_AW+1:2] form `dram_addr`.
- `TURN_CYC`, 1, idle bus cycles inserted after every transaction (0 = none); 0..15.
- `clk` in 1, sole clock; all logic rising-edge.
- `rst` in 1, asynchronous, active-high reset.
- `pN_req` in 1 (N=0,1), request valid; held with fields stable until `pN_ack`.
- `pN_we` in 1, 1 = write, 0 = read.
- `pN_addr` in 32, byte address; bits [1:0] ignored.
- `pN_wdata` in 32, write data.
- `pN_wstrb` in 4, byte enables (1 = write byte).
- `pN_ack` out 1, one-cycle completion pulse.
- `pN_err` out 1, valid with ack; 1 = address out of range.
- `pN_rdata` out 32, read data, valid with ack on reads; held until next read ack on that port.
- `dram_cs`, `dram_ras`, `dram_cas`, `dram_we` out 1 each, active-low command pins.
- `dram_addr` out 14, {zeros, word address}.
- `dram_ba` out 3, constant 0.
- `dram_dq` inout 32, driven only in write CMD cycle, else Z.
- `dram_dm` out 4, data mask = ~wstrb in write CMD, else 4'hF.
- `dram_dqs` out 1, 1 during write CMD, else 0.

## Operation
- Reset values: all acks/errs 0, rdata 0, cs/ras/cas/we 1, dram_addr 0, dm 4'hF, dqs 0, dq Z, state IDLE, last_grant = 1 (so port 0 wins the first tie).
- States: IDLE, CMD, RD_WAIT, DONE, TURN.
- IDLE: if any req is high, grant. With a single requester, that requester wins. With both, the port ≠ last_grant wins. Latch we/addr/wdata/wstrb and update last_grant.
  - If addr[31:MEM_AW+2] ≠ 0, go to DONE with err=1 and issue no command.
  - Otherwise go to CMD.
- CMD (one cycle): cs=ras=cas=0, we=~latched_we, dram_addr=latched word address.
  - Write: drive dq, dm and dqs, then go to DONE.
  - Read: go to RD_WAIT.
- RD_WAIT: command pins idle and dq Z. The memory drives dq during this cycle. Capture dq into the granted port's rdata at the end of the cycle, then go to DONE.
- DONE: assert the granted port's ack (and err if flagged) for exactly one cycle. Go to TURN if TURN_CYC > 0, else IDLE.
- TURN: a 4-bit counter counts TURN_CYC cycles, then goes to IDLE. Requests are not sampled.
- A req still high in IDLE after its ack is a new transaction. A requester drops req on the edge that ends its ack cycle.
- A non-granted req is held pending; it is never lost or reordered.
- rst asserted mid-transaction: immediately return to reset values. The in-flight transaction is dropped with no ack.

## Timing
- Req first high in IDLE cycle T:
  - Write: CMD in T+1, ack in T+2.
  - Read: CMD in T+1, data sampled at end of T+2, ack with rdata in T+3.
  - Error: ack+err in T+1.
- Minimum request spacing (TURN_CYC=1): write 4 cycles, read 5 cycles.
- dq is never driven by both ends: the controller releases dq before RD_WAIT, and the memory output is disabled after RD_WAIT.
- All outputs are registered. There is no combinational path from req to any output.

## Structure
- Package `dram_sched_pkg`:
  - state enum;
  - command constants (CMD_NOP = {cs,ras,cas,we}=4'b1111, CMD_RD=4'b0001, CMD_WR=4'b0000);
  - DM_NONE = 4'hF.
- Sub-module `rr_arb2`: two requests plus last_grant in; one-hot grant out; combinational, used in IDLE.

## Test plan
- Write 0xDEADBEEF to byte address 0x10 on port 1, then read it back: dram_addr=0x004 in CMD, wstrb 4'hF → dm 0. Read acks at T+3 with p1_rdata=0xDEADBEEF.
- Partial write: wstrb 4'b0011 gives dm=4'b1100 in the CMD cycle. dq is Z in every other cycle, checked each cycle.
- Both ports request reads from reset on the same cycle: port 0 is granted first and port 1 is acked 5 cycles later (TURN_CYC=1). Both held continuously: grants alternate 0,1,0,1.
- Port 0 addr=0x1000: ack+err in T+1; cs stays 1 throughout; rdata unchanged.
- TURN_CYC=0 with back-to-back port 0 reads of words 0 and 1: acks 4 cycles apart; rdata matches the preloaded memory image.
- rst asserted during RD_WAIT: outputs return to reset values immediately; no ack. A request after reset is granted to port 0 and completes normally.
